// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matmul output path.
package matmul_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_row_serializer.sv
// Captures a full row-major matrix and streams it out one row per beat.
//
// state | meaning
// IDLE  | no matrix held, ready to capture
// SEND  | presenting row row_cnt of the held matrix
module matrix_row_serializer
  import matmul_pkg::*;
#(
  parameter int ROWS          = 2,
  parameter int COLS          = 2,
  parameter int DATA_WIDTH    = 16,
  parameter int ROW_IDX_WIDTH = safe_clog2(ROWS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ROWS*COLS*DATA_WIDTH-1:0] in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [COLS*DATA_WIDTH-1:0]      out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic [ROW_IDX_WIDTH-1:0]        out_row_idx
);

  localparam int                       ROW_W    = COLS * DATA_WIDTH;
  localparam logic [ROW_IDX_WIDTH-1:0] LAST_ROW = ROW_IDX_WIDTH'(ROWS - 1);

  ser_state_t                     state, state_nxt;
  logic [ROW_IDX_WIDTH-1:0]       row_cnt, row_cnt_nxt;
  logic [ROWS-1:0][ROW_W-1:0]     mat;
  logic                           out_fire;
  logic                           capture;

  assign out_valid   = (state == SEND);
  assign out_last    = out_valid && (row_cnt == LAST_ROW);
  assign out_row_idx = row_cnt;
  assign out_data    = mat[row_cnt];
  assign out_fire    = out_valid && out_ready;
  // Ready on the final beat lets the next matrix land with no bubble.
  assign in_ready    = !rst && ((state == IDLE) || (out_fire && out_last));
  assign capture     = in_valid && in_ready;

  always_comb begin
    state_nxt   = state;
    row_cnt_nxt = row_cnt;
    case (state)
      IDLE: begin
        if (capture) begin
          state_nxt   = SEND;
          row_cnt_nxt = '0;
        end
      end
      SEND: begin
        if (out_fire) begin
          if (!out_last) begin
            row_cnt_nxt = row_cnt + ROW_IDX_WIDTH'(1);
          end else begin
            row_cnt_nxt = '0;
            state_nxt   = capture ? SEND : IDLE;
          end
        end
      end
      default: begin
        state_nxt   = IDLE;
        row_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      row_cnt <= '0;
      mat     <= '0;
    end else begin
      state   <= state_nxt;
      row_cnt <= row_cnt_nxt;
      if (capture) begin
        mat <= in_data;
      end
    end
  end

endmodule
